block_spi_master: RTL and testbench
===================================

Name: block_spi_master

Overview:
- SPI mode-0 (CPOL=0, CPHA=0) master: transmits one byte MSB-first on SPI_MOSI and simultaneously captures one byte from SPI_MISO.
- Initiator counterpart to block_spi_slave. Used for FPGA-to-FPGA loopback tests and for driving external SPI peripherals (e.g. the ECG ADC front-end).
- Sits between fabric logic (start/data handshake) and the SPI pins. Single chip-select; optional CS hold for multi-byte frames.

Parameters:
- CLK_DIV, 4, SCK half-period in clk cycles (legal >= 1); SCK frequency = f_clk / (2*CLK_DIV).

Ports:
- clk  input  1  system clock from block_clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a byte transfer; accepted only in a cycle where busy=0
- data_in  input  8  byte to transmit; latched on the accepting cycle
- hold_cs  input  1  latched with start; 1 keeps SPI_CS low after the byte completes
- release  input  1  in held state, deasserts SPI_CS
- data_out  output  8  last received byte; valid when data_ready pulses, held until the next completion
- data_ready  output  1  single-cycle completion pulse
- busy  output  1  high while a transfer or CS-high guard time is in progress
- SPI_SCK  output  1  serial clock, idle low
- SPI_CS  output  1  chip select, active low
- SPI_MOSI  output  1  serial data out
- SPI_MISO  input  1  serial data in

Behaviour:
- All outputs are registered.
- Reset values: SPI_CS=1, SPI_SCK=0, SPI_MOSI=0, busy=0, data_ready=0, data_out=8'h00, state=IDLE.
- Reset mid-transfer aborts on the next clk edge to these values. No partial data_ready.
- States:
  - IDLE: CS high.
  - SETUP: CS low, SCK low.
  - SCK_HIGH
  - SCK_LOW
  - HELD: CS low, idle.
  - GUARD: CS high, minimum-high time.
- Timing (accepting cycle = cycle 0, D = CLK_DIV):
  - Cycle 1: SPI_CS=0, SPI_MOSI=bit7, busy=1, SCK low; enter SETUP for D cycles.
  - Rising SCK edges at cycles 1+D+2kD, k=0..7.
  - The clk edge that drives SCK high also samples SPI_MISO into the receive shift register, LSB-in.
  - Falling edges at cycles 1+2(k+1)D. MOSI updates to the next bit on falling edges 0..6.
- Completion at cycle 1+16D (8th falling edge):
  - data_out is loaded; data_ready=1 for exactly that cycle; SPI_MOSI returns to 0.
  - hold_cs=0: SPI_CS=1 in the same cycle. GUARD for D cycles, busy=1. busy=0 from cycle 1+17D.
  - hold_cs=1: enter HELD; busy=0 from cycle 1+16D; CS stays low.
- HELD:
  - start begins the next byte with SETUP (CS already low) and re-latches hold_cs.
  - release (without start) → CS high, GUARD D cycles, then IDLE.
  - start and release in the same cycle: start wins, release is ignored.
- Ignored inputs:
  - start while busy=1 is ignored; data_in changes while busy are ignored.
  - release in IDLE or while busy is ignored.
- Counters:
  - Half-period counter counts 0..D-1 and wraps.
  - Bit counter counts 0..7. Terminal at 7 on the falling edge triggers completion.
  - D=1 is legal: SCK toggles every clk cycle.
- SPI_MISO is sampled directly. Synchronising it is the caller's responsibility; it is always board-synchronous in this design.

Decomposition:
- Shared include block_spi_defs.vh holds:
  - state encodings (IDLE, SETUP, SCK_HIGH, SCK_LOW, HELD, GUARD)
  - SPI_BITS=8
- One natural sub-module: block_spi_tick. Parameterised by CLK_DIV, it is a half-period counter with a synchronous clear and a 1-cycle tick output. The FSM uses it for the SETUP, SCK and GUARD timing.

Test Plan:
- Basic byte: CLK_DIV=2, data_in=8'hA5, hold_cs=0, MISO model returns 8'h3C.
  - CS low at cycle 1; 8 SCK rising edges at cycles 3,7,...,31.
  - MOSI bits 1,0,1,0,0,1,0,1.
  - data_ready at cycle 33 with data_out=8'h3C; CS high at 33; busy low at 35.
- Loopback: SPI_MOSI tied to SPI_MISO, CLK_DIV=1, data_in=8'h81 → data_out=8'h81; data_ready at cycle 17; busy low at 18.
- Multi-byte hold: bytes 8'h01 (hold_cs=1), then 8'h02 (hold_cs=1), then release.
  - CS stays low across both bytes; exactly 16 SCK rising edges.
  - CS high the cycle after release; busy high for CLK_DIV cycles afterwards.
- Start while busy: pulse start with 8'hFF mid-transfer of 8'h00 → ignored. MOSI stays 0 throughout; exactly one data_ready.
- Reset mid-transfer: assert rst at bit 4 → next cycle CS=1, SCK=0, MOSI=0, busy=0, data_out=8'h00; no data_ready; a new start then completes normally.
- Start and release together in HELD → new transfer begins, CS never goes high, release has no effect.

Source files
------------

// File: rtl/block_spi_master_pkg.sv
// Shared definitions for the SPI master: FSM state encodings and frame width.
package block_spi_master_pkg;

    localparam int SPI_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SCK_HIGH = 3'd2,
        ST_SCK_LOW  = 3'd3,
        ST_HELD     = 3'd4,
        ST_GUARD    = 3'd5
    } spi_state_t;

endpackage

// File: rtl/block_spi_master_tick.sv
// Half-period timer: counts 0..CLK_DIV-1 and wraps, tick is high on the last count.
module block_spi_master_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // With CLK_DIV=1 the counter sits at 0 and tick stays high every cycle.
    assign tick = (cnt == LAST);

endmodule

// File: rtl/block_spi_master.sv
// SPI mode-0 master: one byte per start, MSB first, optional chip-select hold between bytes.
module block_spi_master
    import block_spi_master_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       hold_cs,
    input  logic       release_cs,
    output logic [7:0] data_out,
    output logic       data_ready,
    output logic       busy,
    output logic       SPI_SCK,
    output logic       SPI_CS,
    output logic       SPI_MOSI,
    input  logic       SPI_MISO
);

    localparam logic [2:0] LAST_BIT = 3'(SPI_BITS - 1);

    spi_state_t state, state_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] tx_sh, tx_sh_nxt;
    logic [7:0] rx_sh, rx_sh_nxt;
    logic [7:0] data_out_nxt;
    logic       hold_q, hold_q_nxt;
    logic       sck_nxt, cs_nxt, mosi_nxt, busy_nxt, ready_nxt;
    logic       tick, tick_clr, accept;

    block_spi_master_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            hold_q     <= 1'b0;
            data_out   <= 8'h00;
            data_ready <= 1'b0;
            busy       <= 1'b0;
            SPI_SCK    <= 1'b0;
            SPI_CS     <= 1'b1;
            SPI_MOSI   <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            tx_sh      <= tx_sh_nxt;
            rx_sh      <= rx_sh_nxt;
            hold_q     <= hold_q_nxt;
            data_out   <= data_out_nxt;
            data_ready <= ready_nxt;
            busy       <= busy_nxt;
            SPI_SCK    <= sck_nxt;
            SPI_CS     <= cs_nxt;
            SPI_MOSI   <= mosi_nxt;
        end
    end

    // A new byte may start from IDLE or from HELD; start outranks release in HELD.
    assign accept = start && !busy && (state == ST_IDLE || state == ST_HELD);

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        tx_sh_nxt    = tx_sh;
        rx_sh_nxt    = rx_sh;
        hold_q_nxt   = hold_q;
        data_out_nxt = data_out;
        ready_nxt    = 1'b0;
        busy_nxt     = busy;
        sck_nxt      = SPI_SCK;
        cs_nxt       = SPI_CS;
        mosi_nxt     = SPI_MOSI;
        tick_clr     = 1'b0;

        if (accept) begin
            state_nxt   = ST_SETUP;
            bit_cnt_nxt = '0;
            tx_sh_nxt   = data_in;
            hold_q_nxt  = hold_cs;
            mosi_nxt    = data_in[7];
            cs_nxt      = 1'b0;
            sck_nxt     = 1'b0;
            busy_nxt    = 1'b1;
            tick_clr    = 1'b1;
        end else begin
            case (state)
                ST_SETUP, ST_SCK_LOW: begin
                    if (tick) begin
                        state_nxt = ST_SCK_HIGH;
                        sck_nxt   = 1'b1;
                        rx_sh_nxt = {rx_sh[6:0], SPI_MISO};
                    end
                end
                ST_SCK_HIGH: begin
                    if (tick) begin
                        sck_nxt = 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            data_out_nxt = rx_sh;
                            ready_nxt    = 1'b1;
                            mosi_nxt     = 1'b0;
                            if (hold_q) begin
                                state_nxt = ST_HELD;
                                busy_nxt  = 1'b0;
                            end else begin
                                state_nxt = ST_GUARD;
                                cs_nxt    = 1'b1;
                            end
                        end else begin
                            state_nxt   = ST_SCK_LOW;
                            bit_cnt_nxt = bit_cnt + 3'd1;
                            tx_sh_nxt   = {tx_sh[6:0], 1'b0};
                            mosi_nxt    = tx_sh[6];
                        end
                    end
                end
                ST_HELD: begin
                    if (release_cs) begin
                        state_nxt = ST_GUARD;
                        cs_nxt    = 1'b1;
                        busy_nxt  = 1'b1;
                        tick_clr  = 1'b1;
                    end
                end
                ST_GUARD: begin
                    if (tick) begin
                        state_nxt = ST_IDLE;
                        busy_nxt  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_block_spi_master.sv
// Directed bench for block_spi_master: a CLK_DIV=2 instance with a MISO slave model
// and a CLK_DIV=1 instance in MOSI->MISO loopback, results checked via expected queues.
module tb_block_spi_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // instance A: CLK_DIV=2, MISO driven by a bench slave model
    logic       start_a = 1'b0, hold_a = 1'b0, rel_a = 1'b0, miso_a;
    logic [7:0] din_a = 8'h00, dout_a;
    logic       rdy_a, busy_a, sck_a, cs_a, mosi_a;

    // instance B: CLK_DIV=1, MOSI looped back onto MISO
    logic       start_b = 1'b0, hold_b = 1'b0, rel_b = 1'b0;
    logic [7:0] din_b = 8'h00, dout_b;
    logic       rdy_b, busy_b, sck_b, cs_b, mosi_b;

    block_spi_master #(.CLK_DIV(2)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .data_in(din_a), .hold_cs(hold_a),
        .release_cs(rel_a), .data_out(dout_a), .data_ready(rdy_a), .busy(busy_a),
        .SPI_SCK(sck_a), .SPI_CS(cs_a), .SPI_MOSI(mosi_a), .SPI_MISO(miso_a)
    );

    block_spi_master #(.CLK_DIV(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .data_in(din_b), .hold_cs(hold_b),
        .release_cs(rel_b), .data_out(dout_b), .data_ready(rdy_b), .busy(busy_b),
        .SPI_SCK(sck_b), .SPI_CS(cs_b), .SPI_MOSI(mosi_b), .SPI_MISO(mosi_b)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q_a[$];
    logic [7:0] exp_q_b[$];

    int         rise_a = 0, rdy_cnt_a = 0, rdy_cnt_b = 0, miso_cnt = 0;
    logic       sck_prev_a = 1'b0;
    logic [7:0] miso_byte_a = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard pops, SCK edge counter and the MISO slave model, all sampled on negedge
    always begin
        logic rising;
        @(negedge clk);
        if (rdy_a) begin
            rdy_cnt_a++;
            if (exp_q_a.size() == 0) begin
                total++; bad++;
                $error("FAIL ready_a_unexpected: observed data_out=%0h expected no ready", dout_a);
            end else check("data_out_a", {24'h0, dout_a}, {24'h0, exp_q_a.pop_front()});
        end
        if (rdy_b) begin
            rdy_cnt_b++;
            if (exp_q_b.size() == 0) begin
                total++; bad++;
                $error("FAIL ready_b_unexpected: observed data_out=%0h expected no ready", dout_b);
            end else check("data_out_b", {24'h0, dout_b}, {24'h0, exp_q_b.pop_front()});
        end
        rising = sck_a && !sck_prev_a;
        if (rising) rise_a++;
        sck_prev_a = sck_a;
        if (cs_a !== 1'b0) miso_cnt = 0;
        else if (rising) miso_cnt++;
        miso_a = miso_byte_a[3'd7 - miso_cnt[2:0]];
    end

    task automatic start_byte_a(input logic [7:0] d, input logic h);
        @(negedge clk);
        din_a = d; hold_a = h; start_a = 1'b1;
    endtask

    // waits from the accepting cycle until busy drops; n = cycle index of busy=0
    task automatic wait_idle_a(input string tag, output int n, output int cs_hi);
        bit done = 0;
        n = 0; cs_hi = 0;
        for (int i = 1; i <= 400 && !done; i++) begin
            @(negedge clk);
            start_a = 1'b0; rel_a = 1'b0;
            if (busy_a && cs_a) cs_hi++;
            if (!busy_a) begin n = i; done = 1; end
        end
        if (!done) begin
            total++; bad++;
            $error("FAIL %s_timeout: observed busy=%0b expected busy=0 within 400 cycles", tag, busy_a);
        end
    endtask

    initial begin
        logic [40:0] tr_sck, tr_cs, tr_mosi, tr_rdy, tr_busy;
        logic [7:0]  pat;
        int n, cs_hi, cnt, base, rbase;

        repeat (3) @(negedge clk);
        check("rst_cs", cs_a, 1);
        check("rst_sck", sck_a, 0);
        check("rst_mosi", mosi_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_ready", rdy_a, 0);
        check("rst_dout", dout_a, 8'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // basic byte A5 out, 3C in
        miso_byte_a = 8'h3C;
        @(negedge clk);
        din_a = 8'hA5; hold_a = 1'b0; start_a = 1'b1;
        exp_q_a.push_back(8'h3C);
        tr_sck[0] = sck_a; tr_cs[0] = cs_a; tr_mosi[0] = mosi_a; tr_rdy[0] = rdy_a; tr_busy[0] = busy_a;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            tr_sck[c] = sck_a; tr_cs[c] = cs_a; tr_mosi[c] = mosi_a; tr_rdy[c] = rdy_a; tr_busy[c] = busy_a;
        end
        check("basic_cs_c1", tr_cs[1], 0);
        check("basic_busy_c1", tr_busy[1], 1);
        pat = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            check("basic_sck_rise", {30'h0, tr_sck[2 + 4*k], tr_sck[3 + 4*k]}, 2'b01);
            check("basic_mosi_bit", tr_mosi[3 + 4*k], pat[7-k]);
        end
        cnt = 0;
        for (int c = 1; c <= 40; c++) if (tr_sck[c] && !tr_sck[c-1]) cnt++;
        check("basic_rise_count", cnt, 8);
        check("basic_ready_c33", tr_rdy[33], 1);
        check("basic_ready_count", $countones(tr_rdy), 1);
        check("basic_cs_c32", tr_cs[32], 0);
        check("basic_cs_c33", tr_cs[33], 1);
        check("basic_mosi_c33", tr_mosi[33], 0);
        check("basic_busy_c34", tr_busy[34], 1);
        check("basic_busy_c35", tr_busy[35], 0);

        // loopback on the CLK_DIV=1 instance
        @(negedge clk);
        din_b = 8'h81; hold_b = 1'b0; start_b = 1'b1;
        exp_q_b.push_back(8'h81);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start_b = 1'b0;
            tr_rdy[c] = rdy_b; tr_busy[c] = busy_b;
        end
        check("lb_ready_c17", tr_rdy[17], 1);
        check("lb_ready_c16", tr_rdy[16], 0);
        check("lb_busy_c17", tr_busy[17], 1);
        check("lb_busy_c18", tr_busy[18], 0);
        check("lb_ready_count", rdy_cnt_b, 1);

        // multi-byte hold, then release
        miso_byte_a = 8'hC6;
        base = rise_a;
        start_byte_a(8'h01, 1'b1);
        exp_q_a.push_back(8'hC6);
        wait_idle_a("hold1", n, cs_hi);
        check("hold1_idle_cycle", n, 33);
        check("hold1_cs_high", cs_hi, 0);
        check("hold1_cs_held", cs_a, 0);
        start_byte_a(8'h02, 1'b1);
        exp_q_a.push_back(8'hC6);
        wait_idle_a("hold2", n, cs_hi);
        check("hold2_cs_high", cs_hi, 0);
        check("hold2_cs_held", cs_a, 0);
        check("hold_rise_count", rise_a - base, 16);
        @(negedge clk);
        rel_a = 1'b1;
        @(negedge clk);
        rel_a = 1'b0;
        check("release_cs_c1", cs_a, 1);
        check("release_busy_c1", busy_a, 1);
        @(negedge clk);
        check("release_busy_c2", busy_a, 1);
        @(negedge clk);
        check("release_busy_c3", busy_a, 0);

        // start while busy is ignored
        miso_byte_a = 8'h5A;
        rbase = rdy_cnt_a;
        start_byte_a(8'h00, 1'b0);
        exp_q_a.push_back(8'h5A);
        cnt = 0; n = 0;
        for (int c = 1; c <= 100 && n == 0; c++) begin
            @(negedge clk);
            start_a = (c == 10);
            if (c == 10) begin din_a = 8'hFF; hold_a = 1'b1; end
            if (mosi_a) cnt++;
            if (!busy_a) n = c;
        end
        check("busy_start_idle_cycle", n, 35);
        check("busy_start_mosi_high", cnt, 0);
        check("busy_start_ready_count", rdy_cnt_a - rbase, 1);
        repeat (4) @(negedge clk);
        check("busy_start_cs_idle", cs_a, 1);
        check("busy_start_still_idle", busy_a, 0);

        // reset mid-transfer at bit 4
        miso_byte_a = 8'h3C;
        base = rise_a;
        start_byte_a(8'hC3, 1'b0);
        exp_q_a.push_back(8'h3C);
        cnt = 0;
        for (int c = 1; c <= 100 && (rise_a - base) < 5; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            cnt = c;
        end
        check("reset_reached_bit4", rise_a - base, 5);
        rbase = rdy_cnt_a;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cs", cs_a, 1);
        check("midrst_sck", sck_a, 0);
        check("midrst_mosi", mosi_a, 0);
        check("midrst_busy", busy_a, 0);
        check("midrst_dout", dout_a, 8'h00);
        check("midrst_ready", rdy_a, 0);
        rst = 1'b0;
        exp_q_a.delete();
        repeat (40) @(negedge clk);
        check("midrst_no_ready", rdy_cnt_a - rbase, 0);
        miso_byte_a = 8'h69;
        start_byte_a(8'h96, 1'b0);
        exp_q_a.push_back(8'h69);
        wait_idle_a("after_rst", n, cs_hi);
        check("after_rst_idle_cycle", n, 35);
        check("after_rst_ready_count", rdy_cnt_a - rbase, 1);

        // start and release together while held
        miso_byte_a = 8'h0F;
        start_byte_a(8'h11, 1'b1);
        exp_q_a.push_back(8'h0F);
        wait_idle_a("sr_first", n, cs_hi);
        check("sr_first_held", cs_a, 0);
        base = rise_a;
        @(negedge clk);
        din_a = 8'h22; hold_a = 1'b0; start_a = 1'b1; rel_a = 1'b1;
        exp_q_a.push_back(8'h0F);
        wait_idle_a("sr_second", n, cs_hi);
        check("sr_second_idle_cycle", n, 35);
        check("sr_second_cs_high", cs_hi, 2);
        check("sr_second_rises", rise_a - base, 8);

        repeat (3) @(negedge clk);
        check("queue_a_empty", exp_q_a.size(), 0);
        check("queue_b_empty", exp_q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
